decode_issue_stage: RTL and testbench

Parametrised decode/issue pipeline stage placed between the fetch register and execute.
- Decodes RV32I/RV64I plus M instructions. Selects operands from the register file or from NUM_FWD forwarding channels.
- Detects load-use hazards and stalls upstream when one occurs.
- Registers all results into one output slot with valid/ready handshakes on both sides.
- Supports flush and counts stall cycles for performance analysis.

---
 rtl/decode_issue_stage_if.sv | 30 +++
 rtl/decode_issue_stage.sv | 168 ++++++++++++++++
 tb/tb_decode_issue_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_stage_if.sv
// Issue-side bundle of decode_issue_stage: registered decode results toward
// execute, with the valid/ready handshake for the single output slot.
interface decode_issue_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic            out_reg_wen;
  logic [11:0]     out_opclass;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic            out_illegal;

  modport master (
    output out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd,
           out_reg_wen, out_opclass, out_func3, out_func7, out_illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd,
           out_reg_wen, out_opclass, out_func3, out_func7, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/decode_issue_stage.sv
// RV32I/RV64I+M decode/issue stage: operand forwarding, load-use stall,
// one registered issue slot toward execute, saturating stall counter.
module decode_issue_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  output logic [4:0]              rf_rs1_addr,
  output logic [4:0]              rf_rs2_addr,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*5-1:0]    fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_is_load,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    flush,
  decode_issue_stage_if.master    iss,
  output logic [CNT_W-1:0]        stall_count
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL    = 7'h6F, OPC_JALR   = 7'h67,
    OPC_REG    = 7'h33, OPC_REGW  = 7'h3B, OPC_IMM    = 7'h13, OPC_IMMW   = 7'h1B,
    OPC_LOAD   = 7'h03, OPC_STORE = 7'h23, OPC_BRANCH = 7'h63, OPC_SYSTEM = 7'h73
  } opcode_e;

  localparam logic IS64 = (XLEN == 64);

  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic [4:0] rs1, rs2, rd;
  logic is_lui, is_auipc, is_jal, is_jalr, is_alu_reg, is_alu_regw;
  logic is_alu_imm, is_alu_immw, is_load, is_store, is_branch, is_system;
  logic [11:0] opclass;
  logic illegal, reg_wen, need_rs1, need_rs2, hazard, accept;
  logic r_bad, ld_bad, st_bad, br_bad;
  logic signed [31:0] imm_raw;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic rs1_load, rs2_load;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign func3  = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign func7  = in_instr[31:25];

  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  // W opcodes decode as unknown on a 32-bit datapath
  assign is_lui      = (opcode == OPC_LUI);
  assign is_auipc    = (opcode == OPC_AUIPC);
  assign is_jal      = (opcode == OPC_JAL);
  assign is_jalr     = (opcode == OPC_JALR);
  assign is_alu_reg  = (opcode == OPC_REG);
  assign is_alu_regw = IS64 && (opcode == OPC_REGW);
  assign is_alu_imm  = (opcode == OPC_IMM);
  assign is_alu_immw = IS64 && (opcode == OPC_IMMW);
  assign is_load     = (opcode == OPC_LOAD);
  assign is_store    = (opcode == OPC_STORE);
  assign is_branch   = (opcode == OPC_BRANCH);
  assign is_system   = (opcode == OPC_SYSTEM);

  assign opclass = {is_lui, is_auipc, is_jal, is_jalr, is_alu_reg, is_alu_regw,
                    is_alu_imm, is_alu_immw, is_load, is_store, is_branch, is_system};

  assign r_bad  = (is_alu_reg || is_alu_regw) &&
                  !(func7 == 7'h00 || func7 == 7'h01 ||
                    (func7 == 7'h20 && (func3 == 3'b000 || func3 == 3'b101)));
  assign ld_bad = is_load && (func3 == 3'b111 ||
                  (!IS64 && (func3 == 3'b011 || func3 == 3'b110)));
  assign st_bad = is_store && (func3 > 3'b011 || (!IS64 && func3 == 3'b011));
  assign br_bad = is_branch && (func3 == 3'b010 || func3 == 3'b011);
  assign illegal = !(|opclass) || r_bad || ld_bad || st_bad || br_bad;

  assign reg_wen = (is_jalr || is_alu_imm || is_alu_immw || is_load || is_lui ||
                    is_auipc || is_jal || is_alu_reg || is_alu_regw) &&
                   !illegal && (rd != 5'd0);

  assign need_rs1 = !(is_lui || is_auipc || is_jal);
  assign need_rs2 = is_alu_reg || is_alu_regw || is_branch || is_store;

  // Every format fits in 32 bits sign-extended from instr[31]; widened at the register
  always_comb begin
    imm_raw = '0;
    if (is_jalr || is_alu_imm || is_alu_immw || is_load)
      imm_raw = {{20{in_instr[31]}}, in_instr[31:20]};
    else if (is_store)
      imm_raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    else if (is_branch)
      imm_raw = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    else if (is_jal)
      imm_raw = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    else if (is_lui || is_auipc)
      imm_raw = {in_instr[31:12], 12'b0};
  end

  // Walk oldest to youngest so the youngest matching channel decides; a load
  // match flags a hazard but never overrides a non-load operand value.
  always_comb begin
    rs1_val  = rf_rdata1;
    rs2_val  = rf_rdata2;
    rs1_load = 1'b0;
    rs2_load = 1'b0;
    for (int unsigned i = NUM_FWD; i > 0; i--) begin
      if (fwd_valid[i-1] && fwd_rd[(i-1)*5 +: 5] == rs1) begin
        rs1_load = fwd_is_load[i-1];
        if (!fwd_is_load[i-1]) rs1_val = fwd_data[(i-1)*XLEN +: XLEN];
      end
      if (fwd_valid[i-1] && fwd_rd[(i-1)*5 +: 5] == rs2) begin
        rs2_load = fwd_is_load[i-1];
        if (!fwd_is_load[i-1]) rs2_val = fwd_data[(i-1)*XLEN +: XLEN];
      end
    end
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  assign hazard   = (need_rs1 && rs1 != 5'd0 && rs1_load) ||
                    (need_rs2 && rs2 != 5'd0 && rs2_load);
  assign in_ready = (!iss.out_valid || iss.out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss.out_valid    <= 1'b0;
      iss.out_pc       <= '0;
      iss.out_rs1_data <= '0;
      iss.out_rs2_data <= '0;
      iss.out_imm      <= '0;
      iss.out_rd       <= '0;
      iss.out_reg_wen  <= 1'b0;
      iss.out_opclass  <= '0;
      iss.out_func3    <= '0;
      iss.out_func7    <= '0;
      iss.out_illegal  <= 1'b0;
      stall_count      <= '0;
    end else begin
      if (flush) begin
        iss.out_valid <= 1'b0;
      end else if (accept) begin
        iss.out_valid    <= 1'b1;
        iss.out_pc       <= in_pc;
        iss.out_rs1_data <= rs1_val;
        iss.out_rs2_data <= rs2_val;
        iss.out_imm      <= XLEN'(imm_raw);
        iss.out_rd       <= rd;
        iss.out_reg_wen  <= reg_wen;
        iss.out_opclass  <= opclass;
        iss.out_func3    <= func3;
        iss.out_func7    <= func7;
        iss.out_illegal  <= illegal;
      end else if (iss.out_ready) begin
        iss.out_valid <= 1'b0;
      end
      if (in_valid && hazard && !flush && !(&stall_count))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: a 64-bit and a 32-bit build driven in lockstep,
// each compared every cycle against a spec-level decode/handshake model.
module tb_decode_issue_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, flush, out_ready;
  logic [31:0]  in_instr;
  logic [63:0]  in_pc, rf_rdata1, rf_rdata2;
  logic [1:0]   fwd_valid, fwd_is_load;
  logic [9:0]   fwd_rd;
  logic [127:0] fwd_data;
  logic [63:0]  fwd_data32;
  logic         in_ready64, in_ready32;
  logic [4:0]   rs1a64, rs2a64, rs1a32, rs2a32;
  logic [31:0]  cnt64;
  logic [1:0]   cnt32;

  decode_issue_stage_if #(.XLEN(64)) bus64 ();
  decode_issue_stage_if #(.XLEN(32)) bus32 ();
  assign bus64.out_ready = out_ready;
  assign bus32.out_ready = out_ready;
  assign fwd_data32 = {fwd_data[95:64], fwd_data[31:0]};

  decode_issue_stage #(.XLEN(64), .NUM_FWD(2), .CNT_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .rf_rs1_addr(rs1a64), .rf_rs2_addr(rs2a64),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_is_load(fwd_is_load), .fwd_data(fwd_data), .flush(flush), .iss(bus64),
    .stall_count(cnt64)
  );

  decode_issue_stage #(.XLEN(32), .NUM_FWD(2), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .rf_rs1_addr(rs1a32), .rf_rs2_addr(rs2a32),
    .rf_rdata1(rf_rdata1[31:0]), .rf_rdata2(rf_rdata2[31:0]), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_is_load(fwd_is_load), .fwd_data(fwd_data32), .flush(flush),
    .iss(bus32), .stall_count(cnt32)
  );

  typedef struct packed {
    logic [63:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        wen;
    logic [11:0] opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
  } slot_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic ev [2];
  slot_t es [2];
  longint unsigned ecnt [2];
  longint unsigned cmax [2] = '{64'hFFFF_FFFF, 64'd3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Class index 0..11 in {lui,auipc,jal,jalr,alu_reg,alu_regw,alu_imm,alu_immw,load,store,branch,system}
  function automatic int op_class(input logic [31:0] ins, input int xlen);
    case (ins[6:0])
      7'h37: return 0;
      7'h17: return 1;
      7'h6F: return 2;
      7'h67: return 3;
      7'h33: return 4;
      7'h3B: return (xlen == 64) ? 5 : -1;
      7'h13: return 6;
      7'h1B: return (xlen == 64) ? 7 : -1;
      7'h03: return 8;
      7'h23: return 9;
      7'h63: return 10;
      7'h73: return 11;
      default: return -1;
    endcase
  endfunction

  function automatic logic [63:0] pick(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd0) return 64'd0;
    for (int i = 0; i < 2; i++)
      if (fwd_valid[i] && !fwd_is_load[i] && fwd_rd[i*5 +: 5] == rs) return fwd_data[i*64 +: 64];
    return rf;
  endfunction

  function automatic logic ref_hazard(input int xlen);
    int c;
    logic [4:0] rs;
    logic need, hz;
    c = op_class(in_instr, xlen);
    hz = 1'b0;
    for (int r = 0; r < 2; r++) begin
      rs   = (r == 0) ? in_instr[19:15] : in_instr[24:20];
      need = (r == 0) ? !(c inside {0, 1, 2}) : (c inside {4, 5, 9, 10});
      if (need && rs != 5'd0)
        for (int i = 0; i < 2; i++)
          if (fwd_valid[i] && fwd_rd[i*5 +: 5] == rs) begin
            if (fwd_is_load[i]) hz = 1'b1;
            break;
          end
    end
    return hz;
  endfunction

  function automatic slot_t ref_decode(input int xlen);
    slot_t s;
    int c;
    logic [31:0] ins;
    longint imm;
    logic [63:0] m;
    logic [2:0] f3;
    logic [6:0] f7;
    ins = in_instr;
    c   = op_class(ins, xlen);
    f3  = ins[14:12];
    f7  = ins[31:25];
    m   = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    imm = 0;
    if (c inside {3, 6, 7, 8}) begin
      imm = ins[31:20];
      if (ins[31]) imm -= 4096;
    end else if (c == 9) begin
      imm = {ins[31:25], ins[11:7]};
      if (ins[31]) imm -= 4096;
    end else if (c == 10) begin
      imm = 2 * ins[11:8] + 32 * ins[30:25] + 2048 * ins[7];
      if (ins[31]) imm -= 4096;
    end else if (c == 2) begin
      imm = 2 * ins[30:21] + 2048 * ins[20] + 4096 * ins[19:12];
      if (ins[31]) imm -= 1048576;
    end else if (c inside {0, 1}) begin
      imm = longint'(ins[31:12]) * 4096;
      if (ins[31]) imm -= longint'(1) << 32;
    end
    s.ill = (c < 0)
         || ((c == 4 || c == 5) && !(f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))))
         || (c == 8 && (f3 == 7 || (xlen == 32 && (f3 == 3 || f3 == 6))))
         || (c == 9 && (f3 > 3 || (xlen == 32 && f3 == 3)))
         || (c == 10 && (f3 == 2 || f3 == 3));
    s.pc  = in_pc & m;
    s.rs1 = pick(ins[19:15], rf_rdata1) & m;
    s.rs2 = pick(ins[24:20], rf_rdata2) & m;
    s.imm = 64'(imm) & m;
    s.rd  = ins[11:7];
    s.wen = (c >= 0 && c <= 8) && !s.ill && ins[11:7] != 5'd0;
    s.opc = (c < 0) ? 12'd0 : (12'd1 << (11 - c));
    s.f3  = f3;
    s.f7  = f7;
    return s;
  endfunction

  task automatic check_outputs();
    slot_t o [2];
    logic ov [2];
    logic [63:0] sc [2];
    string p;
    o[0] = {bus64.out_pc, bus64.out_rs1_data, bus64.out_rs2_data, bus64.out_imm, bus64.out_rd,
            bus64.out_reg_wen, bus64.out_opclass, bus64.out_func3, bus64.out_func7, bus64.out_illegal};
    o[1] = {32'd0, bus32.out_pc, 32'd0, bus32.out_rs1_data, 32'd0, bus32.out_rs2_data, 32'd0,
            bus32.out_imm, bus32.out_rd, bus32.out_reg_wen, bus32.out_opclass, bus32.out_func3,
            bus32.out_func7, bus32.out_illegal};
    ov[0] = bus64.out_valid;
    ov[1] = bus32.out_valid;
    sc[0] = 64'(cnt64);
    sc[1] = 64'(cnt32);
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? "x64" : "x32";
      chk($sformatf("%s.out_valid", p), 64'(ov[k]), 64'(ev[k]));
      chk($sformatf("%s.out_pc", p), o[k].pc, es[k].pc);
      chk($sformatf("%s.out_rs1_data", p), o[k].rs1, es[k].rs1);
      chk($sformatf("%s.out_rs2_data", p), o[k].rs2, es[k].rs2);
      chk($sformatf("%s.out_imm", p), o[k].imm, es[k].imm);
      chk($sformatf("%s.out_rd", p), 64'(o[k].rd), 64'(es[k].rd));
      chk($sformatf("%s.out_reg_wen", p), 64'(o[k].wen), 64'(es[k].wen));
      chk($sformatf("%s.out_opclass", p), 64'(o[k].opc), 64'(es[k].opc));
      chk($sformatf("%s.out_func3", p), 64'(o[k].f3), 64'(es[k].f3));
      chk($sformatf("%s.out_func7", p), 64'(o[k].f7), 64'(es[k].f7));
      chk($sformatf("%s.out_illegal", p), 64'(o[k].ill), 64'(es[k].ill));
      chk($sformatf("%s.stall_count", p), sc[k], 64'(ecnt[k]));
    end
  endtask

  // One clock: check combinational outputs, advance model on the edge, check registers.
  task automatic step();
    logic hz [2];
    logic acc [2];
    logic exp_rdy, f, r, v;
    slot_t nx [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      hz[k]   = ref_hazard((k == 0) ? 64 : 32);
      nx[k]   = ref_decode((k == 0) ? 64 : 32);
      exp_rdy = (!ev[k] || out_ready) && !hz[k] && !flush;
      acc[k]  = in_valid && exp_rdy;
      chk((k == 0) ? "x64.in_ready" : "x32.in_ready",
          64'((k == 0) ? in_ready64 : in_ready32), 64'(exp_rdy));
    end
    chk("x64.rf_rs1_addr", 64'(rs1a64), 64'(in_instr[19:15]));
    chk("x64.rf_rs2_addr", 64'(rs2a64), 64'(in_instr[24:20]));
    chk("x32.rf_rs1_addr", 64'(rs1a32), 64'(in_instr[19:15]));
    chk("x32.rf_rs2_addr", 64'(rs2a32), 64'(in_instr[24:20]));
    f = flush;
    r = out_ready;
    v = in_valid;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (f) ev[k] = 1'b0;
      else if (acc[k]) begin ev[k] = 1'b1; es[k] = nx[k]; end
      else if (r) ev[k] = 1'b0;
      if (v && hz[k] && !f && ecnt[k] < cmax[k]) ecnt[k]++;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0;
      es[k] = '0;
      ecnt[k] = 0;
    end
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0000_0013; in_pc = 64'h0;
    rf_rdata1 = 64'h0; rf_rdata2 = 64'h0;
    fwd_valid = 2'b00; fwd_is_load = 2'b00; fwd_rd = 10'd0; fwd_data = 128'd0;
  endtask

  task automatic rand_inputs();
    logic [6:0] ops [14];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23, 7'h63, 7'h73, 7'h0F, 7'h7F};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(13)];
    w[19:15] = 5'($urandom_range(3));
    w[24:20] = 5'($urandom_range(3));
    case ($urandom_range(3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    in_instr    = w;
    in_pc       = {$urandom, $urandom};
    rf_rdata1   = {$urandom, $urandom};
    rf_rdata2   = {$urandom, $urandom};
    fwd_valid   = 2'($urandom);
    fwd_is_load = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
    fwd_rd      = {5'($urandom_range(3)), 5'($urandom_range(3))};
    fwd_data    = {$urandom, $urandom, $urandom, $urandom};
    in_valid    = ($urandom_range(3) != 0);
    out_ready   = ($urandom_range(3) != 0);
    flush       = ($urandom_range(15) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of random traffic
    for (int n = 0; n < 20; n++) begin rand_inputs(); step(); end
    do_reset();

    // addi x1,x0,5
    idle();
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 64'h1000;
    step();
    chk("t1.out_valid", 64'(bus64.out_valid), 64'd1);
    chk("t1.out_imm", bus64.out_imm, 64'd5);
    chk("t1.out_rd", 64'(bus64.out_rd), 64'd1);
    chk("t1.out_reg_wen", 64'(bus64.out_reg_wen), 64'd1);
    chk("t1.out_rs1_data", bus64.out_rs1_data, 64'd0);
    chk("t1.out_opclass", 64'(bus64.out_opclass), 64'h020);

    // add x3,x1,x2 with both channels matching rs1: youngest wins
    in_instr = 32'h0020_81B3; in_pc = 64'h1004;
    fwd_valid = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_data = {64'h66, 64'h55};
    rf_rdata1 = 64'hAAAA; rf_rdata2 = 64'h7;
    step();
    chk("t2.out_rs1_data", bus64.out_rs1_data, 64'h55);
    chk("t2.out_rs2_data", bus64.out_rs2_data, 64'h7);

    // Load-use stall for two cycles, then forwarded result
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_is_load = 2'b01;
    for (int n = 0; n < 2; n++) begin
      #1 chk("t3.in_ready", 64'(in_ready64), 64'd0);
      step();
    end
    chk("t3.stall_count", 64'(cnt64), 64'd2);
    fwd_is_load = 2'b00; fwd_data = {64'h0, 64'h9};
    step();
    chk("t3.out_rs1_data", bus64.out_rs1_data, 64'h9);

    // beq x1,x2,-4 held under back-pressure, then drained
    fwd_valid = 2'b00; in_instr = 32'hFE20_8EE3;
    step();
    chk("t4.out_imm", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t4.out_reg_wen", 64'(bus64.out_reg_wen), 64'd0);
    out_ready = 1'b0; in_instr = 32'h0050_0093;
    for (int n = 0; n < 3; n++) begin
      #1 chk("t4.in_ready", 64'(in_ready64), 64'd0);
      step();
      chk("t4.hold_imm", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t4.hold_valid", 64'(bus64.out_valid), 64'd1);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    chk("t4.drained", 64'(bus64.out_valid), 64'd0);

    // addw: legal only on the 64-bit build
    in_valid = 1'b1; in_instr = 32'h0020_81BB;
    step();
    chk("t5.x32_illegal", 64'(bus32.out_illegal), 64'd1);
    chk("t5.x32_reg_wen", 64'(bus32.out_reg_wen), 64'd0);
    chk("t5.x64_illegal", 64'(bus64.out_illegal), 64'd0);
    chk("t5.x64_opclass", 64'(bus64.out_opclass), 64'h040);

    // Flush with a held slot and a pending instruction
    out_ready = 1'b0; in_instr = 32'h0050_0093;
    step();
    flush = 1'b1;
    step();
    chk("t6.flush_valid", 64'(bus64.out_valid), 64'd0);
    flush = 1'b0; out_ready = 1'b1;

    // Five stall cycles saturate the 2-bit counter; flush freezes it
    in_instr = 32'h0020_81B3; fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_is_load = 2'b01;
    for (int n = 0; n < 5; n++) step();
    chk("t6.x32_stall_sat", 64'(cnt32), 64'd3);
    chk("t6.x64_stall", 64'(cnt64), 64'd7);
    flush = 1'b1;
    step();
    chk("t6.flush_stall", 64'(cnt64), 64'd7);
    chk("t6.flush_noaccept", 64'(bus64.out_valid), 64'd0);

    // Random traffic with a reset in the middle
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      step();
      if (n == 150) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
